// File: rtl/jogo_pkg.sv
// Shared game constants, controller state encoding and saturating score add.
// Pure definitions: no latency, no flow control.
package jogo_pkg;
    localparam int ALTURA_TELA  = 480;
    localparam int LARGURA_TELA = 640;
    localparam int COORD_W      = 10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        GRACE    = 3'd2,
        FLIGHT   = 3'd3,
        HIT      = 3'd4,
        COOLDOWN = 3'd5
    } estado_t;

    function automatic logic [15:0] soma_saturada(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction
endpackage

// File: rtl/controle_disparo_if.sv
// Projectile/target/score bundle between the shot controller and the game side.
// Wires only: no latency, no flow control (pulses are single-cycle strobes).
interface controle_disparo_if;
    import jogo_pkg::*;

    logic [COORD_W-1:0] bola_x;
    logic [COORD_W-1:0] bola_y;
    logic [COORD_W-1:0] bola_raio;
    logic [COORD_W-1:0] alvo_x;
    logic [COORD_W-1:0] alvo_y;
    logic [COORD_W-1:0] alvo_largura;
    logic [COORD_W-1:0] alvo_altura;
    logic               alvo_vivo;
    logic               iniciar_movimento;
    logic               bola_ativa;
    logic               acerto;
    logic               perdido;
    logic [15:0]        pontos;
    logic [2:0]         estado;

    modport master (
        input  bola_x, bola_y, bola_raio, alvo_x, alvo_y, alvo_largura, alvo_altura, alvo_vivo,
        output iniciar_movimento, bola_ativa, acerto, perdido, pontos, estado
    );

    modport slave (
        output bola_x, bola_y, bola_raio, alvo_x, alvo_y, alvo_largura, alvo_altura, alvo_vivo,
        input  iniciar_movimento, bola_ativa, acerto, perdido, pontos, estado
    );
endinterface

// File: rtl/sincronizador_botao.sv
// 2-FF synchroniser for the raw fire button plus rising-edge detect.
// nivel is 2 cycles behind the pin, borda pulses for one cycle alongside it; no backpressure.
module sincronizador_botao (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic i_botao,
    output logic o_nivel,
    output logic o_borda
);
    logic r_sinc1;
    logic r_sinc2;
    logic r_sinc2_ant;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sinc1     <= 1'b0;
            r_sinc2     <= 1'b0;
            r_sinc2_ant <= 1'b0;
        end else begin
            r_sinc1     <= i_botao;
            r_sinc2     <= r_sinc1;
            r_sinc2_ant <= r_sinc2;
        end
    end

    assign o_nivel = r_sinc2;
    assign o_borda = r_sinc2 & ~r_sinc2_ant;
endmodule

// File: rtl/controle_disparo.sv
// Shot controller: fire request -> launch pulse, grace, registered hit/miss check, score, cooldown.
// Launch 3 cycles after the button edge, verdict 1 cycle after sampling; AUTO_FIRE_EN fires on held level. pausa freezes everything.
module controle_disparo #(
    parameter int ALTURA_TELA     = jogo_pkg::ALTURA_TELA,
    parameter int GRACE_CICLOS    = 100_000,
    parameter int COOLDOWN_CICLOS = 2_500_000,
    parameter int PONTOS_ACERTO   = 10
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               pausa,
    input  logic               reiniciarJogo,
    input  logic               botao_tiro,
    controle_disparo_if.master bus
);
    import jogo_pkg::*;

    localparam logic [31:0] GRACE_FIM    = 32'(GRACE_CICLOS - 1);
    localparam logic [31:0] COOLDOWN_FIM = 32'(COOLDOWN_CICLOS - 1);
    localparam logic [15:0] INCREMENTO   = 16'(PONTOS_ACERTO);
    localparam logic [10:0] LIMITE_Y     = 11'(ALTURA_TELA);

    estado_t     r_estado, w_estado_prox;
    logic [31:0] r_cnt, w_cnt_prox;
    logic [15:0] r_pontos, w_pontos_prox;
    logic        r_hit, r_fora, r_chk_vld;
    logic        w_nivel, w_borda, w_pedido;
    logic        w_colisao, w_fora;
    logic        w_inicia, w_acerto, w_perdido;
    logic [10:0] w_bx, w_by, w_br, w_ax, w_ay, w_al, w_ah;

    sincronizador_botao u_sinc (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .i_botao  (botao_tiro),
        .o_nivel  (w_nivel),
        .o_borda  (w_borda)
    );

    // borda implies nivel, so each form below reduces to the intended single source.
`ifdef AUTO_FIRE_EN
    assign w_pedido = w_nivel | w_borda;
`else
    assign w_pedido = w_borda & w_nivel;
`endif

    assign w_bx = {1'b0, bus.bola_x};
    assign w_by = {1'b0, bus.bola_y};
    assign w_br = {1'b0, bus.bola_raio};
    assign w_ax = {1'b0, bus.alvo_x};
    assign w_ay = {1'b0, bus.alvo_y};
    assign w_al = {1'b0, bus.alvo_largura};
    assign w_ah = {1'b0, bus.alvo_altura};

    assign w_colisao = bus.alvo_vivo
                     & (w_bx + w_br >= w_ax) & (w_bx <= w_ax + w_al + w_br)
                     & (w_by + w_br >= w_ay) & (w_by <= w_ay + w_ah + w_br);
    assign w_fora    = (w_by >= LIMITE_Y) | (w_by < w_br);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_estado  <= IDLE;
            r_cnt     <= '0;
            r_pontos  <= '0;
            r_hit     <= 1'b0;
            r_fora    <= 1'b0;
            r_chk_vld <= 1'b0;
        end else begin
            r_estado <= w_estado_prox;
            r_cnt    <= w_cnt_prox;
            r_pontos <= w_pontos_prox;
            if (reiniciarJogo) begin
                r_hit     <= 1'b0;
                r_fora    <= 1'b0;
                r_chk_vld <= 1'b0;
            end else if (!pausa) begin
                // Verdict only trusted once coordinates were sampled inside FLIGHT.
                r_hit     <= w_colisao;
                r_fora    <= w_fora;
                r_chk_vld <= (r_estado == FLIGHT);
            end
        end
    end

    always_comb begin
        w_estado_prox = r_estado;
        w_cnt_prox    = r_cnt;
        w_pontos_prox = r_pontos;
        w_inicia      = 1'b0;
        w_acerto      = 1'b0;
        w_perdido     = 1'b0;
        if (reiniciarJogo) begin
            w_estado_prox = IDLE;
            w_cnt_prox    = '0;
            w_pontos_prox = '0;
        end else if (!pausa) begin
            case (r_estado)
                IDLE:   if (w_pedido) w_estado_prox = LAUNCH;
                LAUNCH: begin
                    w_inicia      = 1'b1;
                    w_cnt_prox    = '0;
                    w_estado_prox = GRACE;
                end
                GRACE: begin
                    if (r_cnt == GRACE_FIM) begin
                        w_cnt_prox    = '0;
                        w_estado_prox = FLIGHT;
                    end else begin
                        w_cnt_prox = r_cnt + 32'd1;
                    end
                end
                FLIGHT: begin
                    if (r_chk_vld && r_hit) begin
                        w_estado_prox = HIT;
                    end else if (r_chk_vld && r_fora) begin
                        w_perdido     = 1'b1;
                        w_cnt_prox    = '0;
                        w_estado_prox = COOLDOWN;
                    end
                end
                HIT: begin
                    w_acerto      = 1'b1;
                    w_pontos_prox = soma_saturada(r_pontos, INCREMENTO);
                    w_cnt_prox    = '0;
                    w_estado_prox = COOLDOWN;
                end
                COOLDOWN: begin
                    if (r_cnt == COOLDOWN_FIM) begin
                        w_cnt_prox    = '0;
                        w_estado_prox = IDLE;
                    end else begin
                        w_cnt_prox = r_cnt + 32'd1;
                    end
                end
                default: begin
                    w_cnt_prox    = '0;
                    w_estado_prox = IDLE;
                end
            endcase
        end
    end

    assign bus.iniciar_movimento = w_inicia;
    assign bus.acerto            = w_acerto;
    assign bus.perdido           = w_perdido;
    assign bus.bola_ativa        = (r_estado == GRACE) || (r_estado == FLIGHT);
    assign bus.pontos            = r_pontos;
    assign bus.estado            = r_estado;
endmodule

// File: tb/tb_controle_disparo.sv
// Directed bench for controle_disparo with short grace/cooldown counts.
module tb_controle_disparo;
    import jogo_pkg::*;

    logic CLOCK_50 = 1'b0;
    logic reset;
    logic pausa;
    logic reiniciarJogo;
    logic botao_tiro;
    int   n_cmp = 0;
    int   n_err = 0;

    controle_disparo_if bus ();

    controle_disparo #(
        .GRACE_CICLOS    (4),
        .COOLDOWN_CICLOS (8)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .pausa         (pausa),
        .reiniciarJogo (reiniciarJogo),
        .botao_tiro    (botao_tiro),
        .bus           (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic passo(input int n = 1);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic esperar(input logic [2:0] alvo_est, input int max, input string tag);
        int n = 0;
        while (bus.estado !== alvo_est && n < max) begin
            passo();
            n++;
        end
        chk(tag, 32'(bus.estado), 32'(alvo_est));
    endtask

    task automatic disparar(input string tag);
        botao_tiro = 1'b1;
        esperar(3'(LAUNCH), 10, tag);
        passo();
        botao_tiro = 1'b0;
    endtask

    task automatic pos_bola(input int x, input int y, input int r);
        bus.bola_x    = 10'(x);
        bus.bola_y    = 10'(y);
        bus.bola_raio = 10'(r);
    endtask

    task automatic pos_alvo(input int x, input int y, input int l, input int h);
        bus.alvo_x       = 10'(x);
        bus.alvo_y       = 10'(y);
        bus.alvo_largura = 10'(l);
        bus.alvo_altura  = 10'(h);
    endtask

    initial begin
        int  c;
        logic viu;
        reset = 1'b1; pausa = 1'b0; reiniciarJogo = 1'b0; botao_tiro = 1'b0;
        bus.alvo_vivo = 1'b1;
        pos_bola(100, 50, 5);
        pos_alvo(90, 40, 20, 10);
        passo(3);
        chk("rst_estado", 32'(bus.estado), 0);
        chk("rst_pontos", 32'(bus.pontos), 0);
        chk("rst_pulsos", {29'd0, bus.iniciar_movimento, bus.acerto, bus.perdido}, 0);
        chk("rst_ativa", 32'(bus.bola_ativa), 0);
        reset = 1'b0;
        passo(2);

        // Launch latency and hit on (100,50) r=5 vs box (90,40,20,10).
        botao_tiro = 1'b1;
        passo(2);
        chk("t1_sem_pulso_cedo", 32'(bus.iniciar_movimento), 0);
        passo();
        chk("t1_inicia", 32'(bus.iniciar_movimento), 1);
        chk("t1_launch", 32'(bus.estado), 1);
        passo();
        chk("t1_inicia_1ciclo", 32'(bus.iniciar_movimento), 0);
        chk("t1_grace", 32'(bus.estado), 2);
        chk("t1_ativa", 32'(bus.bola_ativa), 1);
        botao_tiro = 1'b0;
        passo(3);
        chk("t1_grace_fim", 32'(bus.estado), 2);
        passo();
        chk("t2_flight", 32'(bus.estado), 3);
        passo();
        chk("t2_amostra", 32'(bus.acerto), 0);
        passo();
        chk("t2_hit", 32'(bus.estado), 4);
        chk("t2_acerto", 32'(bus.acerto), 1);
        chk("t2_pontos_antes", 32'(bus.pontos), 0);
        passo();
        chk("t2_acerto_1ciclo", 32'(bus.acerto), 0);
        chk("t2_pontos", 32'(bus.pontos), 10);
        c = 1;
        while (bus.estado == 3'd5 && c < 30) begin
            passo();
            if (bus.estado == 3'd5) c++;
        end
        chk("t2_cooldown_len", 32'(c), 8);
        chk("t2_idle", 32'(bus.estado), 0);

        // Miss: off-screen at y=480, no overlap.
        pos_bola(300, 480, 5);
        passo(2);
        disparar("t3_launch");
        esperar(3'(FLIGHT), 20, "t3_flight");
        passo();
        chk("t3_perdido", 32'(bus.perdido), 1);
        chk("t3_sem_acerto", 32'(bus.acerto), 0);
        passo();
        chk("t3_perdido_1ciclo", 32'(bus.perdido), 0);
        chk("t3_cooldown", 32'(bus.estado), 5);
        chk("t3_pontos", 32'(bus.pontos), 10);
        esperar(3'(IDLE), 20, "t3_idle");

        // Overlap while y=2 < r=5: hit wins over off-screen.
        pos_bola(100, 2, 5);
        pos_alvo(90, 0, 20, 10);
        passo(2);
        disparar("t4_launch");
        esperar(3'(FLIGHT), 20, "t4_flight");
        passo();
        chk("t4_perdido_amostra", 32'(bus.perdido), 0);
        passo();
        chk("t4_acerto", 32'(bus.acerto), 1);
        chk("t4_perdido", 32'(bus.perdido), 0);
        passo();
        chk("t4_pontos", 32'(bus.pontos), 20);
        esperar(3'(IDLE), 20, "t4_idle");
        pos_alvo(90, 40, 20, 10);

        // Presses during FLIGHT and COOLDOWN are dropped.
        pos_bola(300, 300, 5);
        passo(2);
        disparar("t5_launch");
        esperar(3'(FLIGHT), 20, "t5_flight");
        viu = 1'b0;
        botao_tiro = 1'b1;
        for (int i = 0; i < 8; i++) begin
            passo();
            if (bus.iniciar_movimento) viu = 1'b1;
        end
        botao_tiro = 1'b0;
        chk("t5_sem_relanc_flight", 32'(viu), 0);
        chk("t5_ainda_flight", 32'(bus.estado), 3);
        pos_bola(300, 480, 5);
        esperar(3'(COOLDOWN), 5, "t5_cooldown");
        botao_tiro = 1'b1;
        esperar(3'(IDLE), 20, "t5_idle");
`ifdef AUTO_FIRE_EN
        passo();
        chk("t5_autofire_relanc", 32'(bus.estado), 1);
        botao_tiro = 1'b0;
        esperar(3'(COOLDOWN), 30, "t5_auto_cooldown");
        esperar(3'(IDLE), 20, "t5_auto_idle");
`else
        viu = 1'b0;
        for (int i = 0; i < 10; i++) begin
            passo();
            if (bus.estado != 3'd0) viu = 1'b1;
        end
        chk("t5_segurado_tiro_unico", 32'(viu), 0);
        botao_tiro = 1'b0;
`endif
        chk("t5_pontos", 32'(bus.pontos), 20);

        // Pause mid-GRACE, then saturation with a pulse held across pause.
        force dut.r_pontos = 16'hFFF8;
        passo();
        release dut.r_pontos;
        pos_bola(300, 300, 5);
        passo(2);
        disparar("t6_launch");
        passo();
        pausa = 1'b1;
        viu = 1'b0;
        for (int i = 0; i < 50; i++) begin
            passo();
            if (bus.estado != 3'd2 || bus.iniciar_movimento) viu = 1'b1;
        end
        chk("t6_congelado", 32'(viu), 0);
        pausa = 1'b0;
        c = 0;
        while (bus.estado != 3'd3 && c < 20) begin
            passo();
            c++;
        end
        chk("t6_grace_retoma", 32'(c), 3);
        pos_bola(100, 50, 5);
        esperar(3'(HIT), 5, "t6_hit");
        chk("t6_acerto", 32'(bus.acerto), 1);
        pausa = 1'b1;
        #1;
        chk("t6_acerto_pausa", 32'(bus.acerto), 0);
        passo();
        chk("t6_hit_retido", 32'(bus.estado), 4);
        chk("t6_pontos_retido", 32'(bus.pontos), 32'hFFF8);
        pausa = 1'b0;
        #1;
        chk("t6_acerto_pendente", 32'(bus.acerto), 1);
        passo();
        chk("t6_saturado", 32'(bus.pontos), 32'hFFFF);
        esperar(3'(IDLE), 20, "t6_idle");

        // Soft clear mid-FLIGHT.
        pos_bola(300, 300, 5);
        passo(2);
        disparar("t6_launch2");
        esperar(3'(FLIGHT), 20, "t6_flight2");
        passo(3);
        reiniciarJogo = 1'b1;
        passo();
        chk("t6_reinicia_estado", 32'(bus.estado), 0);
        chk("t6_reinicia_pontos", 32'(bus.pontos), 0);
        chk("t6_reinicia_ativa", 32'(bus.bola_ativa), 0);
        reiniciarJogo = 1'b0;
        passo(3);
        chk("t6_fica_idle", 32'(bus.estado), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
